// File: rtl/mult256_operand_loader.sv
// mult256_operand_loader
//
// Upstream operand stage for the 256-bit combinational multiplier. Two
// operands, A then B, are assembled least-significant word first from a
// valid/ready word stream. Once B is complete the operands are held for
// SETTLE_CYCLES clocks so the multiplier output can resolve. op_valid is then
// raised and held until the product capture logic returns op_ack, after which
// the loader re-arms for the next pair.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clear     synchronous abort/flush; drops any word offered in the same cycle
//   in_data   operand word, least-significant word first
//   in_valid  in_data is valid
//   in_ready  loader accepts a word this cycle (LOAD_A / LOAD_B only)
//   A_out     operand A to the multiplier
//   B_out     operand B to the multiplier
//   op_valid  A_out/B_out loaded and settled
//   op_ack    consumer has captured the product (honoured only while op_valid)
//   busy      a pair is partially or fully loaded and not yet acknowledged
//   word_cnt  words accepted for the current pair, 0..16

module mult256_operand_loader #(
  parameter int WORD_W        = 32,
  parameter int OP_W          = 256,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OP_W-1:0]   A_out,
  output logic [OP_W-1:0]   B_out,
  output logic              op_valid,
  input  logic              op_ack,
  output logic              busy,
  output logic [4:0]        word_cnt
);

  localparam int NW    = OP_W / WORD_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NW - 1);
  // Settle counter counts down to zero, so it starts one below the hold time.
  localparam logic [7:0]       SETTLE_INIT = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    SETTLE,
    PRESENT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] widx_q;
  logic [7:0]       settle_q;
  logic             accept;
  logic             last_word;

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    op_valid  = (state_q == PRESENT);
    busy      = (word_cnt != 5'd0) || (state_q == SETTLE) || (state_q == PRESENT);
    accept    = in_valid && in_ready;
    last_word = (widx_q == LAST_IDX);

    case (state_q)
      LOAD_A: begin
        if (accept && last_word) state_d = LOAD_B;
      end
      LOAD_B: begin
        if (accept && last_word) state_d = (SETTLE_CYCLES > 0) ? SETTLE : PRESENT;
      end
      SETTLE: begin
        if (settle_q == 8'd0) state_d = PRESENT;
      end
      PRESENT: begin
        if (op_ack) state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase

    // Flush wins over any accept or acknowledge in the same cycle.
    if (clear) state_d = LOAD_A;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand assembly, word counting and settle timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_out    <= '0;
      B_out    <= '0;
      word_cnt <= 5'd0;
      widx_q   <= '0;
      settle_q <= 8'd0;
    end else if (clear) begin
      A_out    <= '0;
      B_out    <= '0;
      word_cnt <= 5'd0;
      widx_q   <= '0;
      settle_q <= 8'd0;
    end else begin
      if (accept) begin
        if (state_q == LOAD_A) begin
          A_out[widx_q*WORD_W +: WORD_W] <= in_data;
        end else begin
          B_out[widx_q*WORD_W +: WORD_W] <= in_data;
        end
        word_cnt <= word_cnt + 5'd1;
        widx_q   <= last_word ? '0 : widx_q + IDX_W'(1);
      end

      if ((state_q == LOAD_B) && accept && last_word) begin
        settle_q <= SETTLE_INIT;
      end else if ((state_q == SETTLE) && (settle_q != 8'd0)) begin
        settle_q <= settle_q - 8'd1;
      end

      // Operands are deliberately kept on acknowledge; only the count re-arms.
      if ((state_q == PRESENT) && op_ack) begin
        word_cnt <= 5'd0;
      end
    end
  end

endmodule
